image_stream_loader: RTL and testbench
======================================

Name: image_stream_loader

Overview:
Producer side of the CNN image/label interface. It accepts a serial byte stream of labelled images and converts each 8-bit pixel to Q(WIDTH-FIXED_POINT_INDEX).FIXED_POINT_INDEX fixed point. It assembles full 2-D frames plus one-hot label vectors into a double buffer and holds each frame stable for the CNN top until the CNN signals it has finished with that image. It sits between the external dataset source (DMA/UART/testbench) and the CNN top's input_data/input_labels ports.

Parameters:
WIDTH, 32, fixed-point word width
FIXED_POINT_INDEX, 16, fractional bits
INPUT_DIM_WIDTH, 28, frame columns
INPUT_DIM_HEIGHT, 28, frame rows
NUM_CLASSES, 10, label vector length
NUM_IMAGES, 10000, images per run
PIXEL_BITS, 8, raw pixel width (must be ≤ FIXED_POINT_INDEX)
LABEL_HOT_VALUE, 1<<FIXED_POINT_INDEX, value written to the hot label element

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
label_valid  in  1  label beat present
label_data  in  4  class index of next image
label_ready  out  1  loader accepts label beat
pix_valid  in  1  pixel beat present
pix_data  in  PIXEL_BITS  raw unsigned pixel, row-major
pix_ready  out  1  loader accepts pixel beat
consume  in  1  one-cycle pulse: CNN finished current frame (driven from softmax_done/UPDATE_WEIGHTS)
output_data  out  signed WIDTH x [INPUT_DIM_HEIGHT][INPUT_DIM_WIDTH]  current frame
output_labels  out  signed WIDTH x [NUM_CLASSES]  one-hot label of current frame
frame_valid  out  1  output_data/output_labels hold a complete frame
image_index  out  $clog2(NUM_IMAGES)  index of the frame currently presented
label_error  out  1  sticky: out-of-range label seen
all_done  out  1  sticky: NUM_IMAGES frames consumed

Behaviour:
- Reset: asynchronous, active-low; clock clk. All of the following are 0 during/after reset: outputs, bank count, pointers, loaded/consumed counters, and state (LOAD_LABEL). Bank contents need no reset. Reset mid-frame discards the partial frame.
- Storage: two banks, each holding a frame and a label vector. fill_ptr and rd_ptr are 1 bit each. full_cnt ranges 0..2.
- Per-image stream format: one label beat, then INPUT_DIM_HEIGHT*INPUT_DIM_WIDTH pixel beats in row-major order (col increments fastest).
- A transfer occurs when valid && ready in the same cycle. Valid may drop at any beat with no effect other than a stall.
- FSM:
  - LOAD_LABEL: label_ready = (full_cnt<2 or consume this cycle) && loaded<NUM_IMAGES. On label transfer, write the one-hot vector into bank[fill_ptr], clear row/col, go to LOAD_PIX.
  - LOAD_PIX: pix_ready = 1. On each transfer, bank[fill_ptr][row][col] = zero-extended pix_data << (FIXED_POINT_INDEX-PIXEL_BITS). On the last pixel (row=H-1, col=W-1): toggle fill_ptr, full_cnt++, loaded++. Then go to LOAD_LABEL, or to STOPPED if loaded reaches NUM_IMAGES.
  - STOPPED: both ready signals held at 0 until reset.
- Label encoding: element[label_data] = LABEL_HOT_VALUE, all others 0. If label_data ≥ NUM_CLASSES, the vector is all-zero, label_error is set (sticky), and the pixels are still loaded normally.
- frame_valid = (full_cnt != 0). output_data and output_labels are driven from bank[rd_ptr] and are stable while frame_valid=1 and no consume occurs.
- Latency: the cycle after the last pixel transfer, frame_valid=1 (when the buffer was previously empty).
- consume with frame_valid=1: rd_ptr toggles, full_cnt--, image_index++ (registered, visible next cycle). When the consumed count reaches NUM_IMAGES, all_done=1 and image_index holds at NUM_IMAGES-1.
- consume with frame_valid=0: ignored, no state change.
- Simultaneous last-pixel and consume: full_cnt unchanged, both pointers toggle.
- When full_cnt=2, label_ready=0 (back-pressure) unless consume occurs in the same cycle.
- The bank being filled is never the bank presented, except in the full_cnt=0 case, where frame_valid=0.

Test Plan:
- Reset, then stream label 3 and 784 pixels all 0xFF. Expect: frame_valid rises exactly 1 cycle after the last pixel; every output_data = 0x0000FF00; output_labels[3] = 0x00010000 and all others 0; image_index = 0.
- Load 3 frames with no consume. Expect: after 2 frames, label_ready=0 and the 3rd label stalls. Pulse consume: image_index=1, label_ready=1 in the same cycle, frame 2 data presented.
- With full_cnt=1, time consume to coincide with the last pixel of the next frame. Expect: full_cnt stays 1, frame_valid stays 1, the newly loaded frame is presented next cycle.
- Label 12. Expect: all output_labels=0, label_error=1 and stays 1 through later valid frames.
- NUM_IMAGES=3: load and consume 3 frames. Expect: STOPPED (both ready=0), all_done=1 after the 3rd consume, image_index=2. A consume pulse when frame_valid=0 has no effect.
- Assert reset after 400 pixels, release, and send a fresh image with pixel value = index mod 256, with random pix_valid gaps. Expect: output_data[r][c] = ((r*28+c) mod 256)<<8 and no residue from the aborted frame.

Source files
------------

// File: rtl/image_stream_loader.sv
// Image stream loader: turns a serial label+pixel byte stream into fixed-point
// frames and one-hot label vectors held in a two-bank buffer. The presented
// bank stays stable until the CNN pulses consume.
module image_stream_loader #(
    parameter int               WIDTH             = 32,
    parameter int               FIXED_POINT_INDEX = 16,
    parameter int               INPUT_DIM_WIDTH   = 28,
    parameter int               INPUT_DIM_HEIGHT  = 28,
    parameter int               NUM_CLASSES       = 10,
    parameter int               NUM_IMAGES        = 10000,
    parameter int               PIXEL_BITS        = 8,
    parameter logic [WIDTH-1:0] LABEL_HOT_VALUE   = WIDTH'(1 << FIXED_POINT_INDEX),
    localparam int              IDX_W = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    label_valid,
    input  logic [3:0]              label_data,
    output logic                    label_ready,
    input  logic                    pix_valid,
    input  logic [PIXEL_BITS-1:0]   pix_data,
    output logic                    pix_ready,
    input  logic                    consume,
    output logic signed [WIDTH-1:0] output_data [INPUT_DIM_HEIGHT][INPUT_DIM_WIDTH],
    output logic signed [WIDTH-1:0] output_labels [NUM_CLASSES],
    output logic                    frame_valid,
    output logic [IDX_W-1:0]        image_index,
    output logic                    label_error,
    output logic                    all_done
);

    localparam int ROW_W = (INPUT_DIM_HEIGHT > 1) ? $clog2(INPUT_DIM_HEIGHT) : 1;
    localparam int COL_W = (INPUT_DIM_WIDTH > 1) ? $clog2(INPUT_DIM_WIDTH) : 1;
    localparam int CNT_W = $clog2(NUM_IMAGES + 1);

    typedef enum logic [1:0] {LOAD_LABEL, LOAD_PIX, STOPPED} state_t;

    state_t             state_q, state_d;
    logic               fill_ptr_q, fill_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         full_cnt_q, full_cnt_d;
    logic [CNT_W-1:0]   loaded_q, loaded_d;
    logic [CNT_W-1:0]   consumed_q, consumed_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [IDX_W-1:0]   image_index_q, image_index_d;
    logic               label_error_q, label_error_d;
    logic               all_done_q, all_done_d;

    logic               label_fire;
    logic               pix_fire;
    logic               last_pix;
    logic               consume_fire;
    logic [WIDTH-1:0]   pix_fixed;

    // Frame and label storage; no reset needed since full_cnt gates visibility.
    logic signed [WIDTH-1:0] bank_pix [2][INPUT_DIM_HEIGHT][INPUT_DIM_WIDTH];
    logic signed [WIDTH-1:0] bank_lbl [2][NUM_CLASSES];

    assign label_fire   = label_valid && label_ready;
    assign pix_fire     = pix_valid && pix_ready;
    assign last_pix     = pix_fire && (row_q == ROW_W'(INPUT_DIM_HEIGHT - 1))
                                   && (col_q == COL_W'(INPUT_DIM_WIDTH - 1));
    assign consume_fire = consume && (full_cnt_q != 2'd0);
    assign pix_fixed    = {{(WIDTH - PIXEL_BITS){1'b0}}, pix_data} << (FIXED_POINT_INDEX - PIXEL_BITS);

    // Next-state, handshake and buffer bookkeeping.
    always_comb begin
        state_d       = state_q;
        fill_ptr_d    = fill_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        full_cnt_d    = full_cnt_q;
        loaded_d      = loaded_q;
        consumed_d    = consumed_q;
        row_d         = row_q;
        col_d         = col_q;
        image_index_d = image_index_q;
        label_error_d = label_error_q;
        all_done_d    = all_done_q;
        label_ready   = 1'b0;
        pix_ready     = 1'b0;

        case (state_q)
            LOAD_LABEL: begin
                // A consume in the same cycle frees a bank, so accept then too.
                label_ready = ((full_cnt_q != 2'd2) || consume)
                              && (loaded_q < CNT_W'(NUM_IMAGES));
                if (label_fire) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = LOAD_PIX;
                    if (int'(label_data) >= NUM_CLASSES) begin
                        label_error_d = 1'b1;
                    end
                end
            end
            LOAD_PIX: begin
                pix_ready = 1'b1;
                if (pix_fire) begin
                    if (col_q == COL_W'(INPUT_DIM_WIDTH - 1)) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
                if (last_pix) begin
                    fill_ptr_d = ~fill_ptr_q;
                    loaded_d   = loaded_q + CNT_W'(1);
                    state_d    = (loaded_q == CNT_W'(NUM_IMAGES - 1)) ? STOPPED : LOAD_LABEL;
                end
            end
            default: ; // STOPPED: wait for reset
        endcase

        if (consume_fire) begin
            rd_ptr_d   = ~rd_ptr_q;
            consumed_d = consumed_q + CNT_W'(1);
            if (consumed_q == CNT_W'(NUM_IMAGES - 1)) begin
                all_done_d = 1'b1;
            end else begin
                image_index_d = image_index_q + IDX_W'(1);
            end
        end

        // Completion and consume in the same cycle cancel out.
        if (last_pix && !consume_fire) begin
            full_cnt_d = full_cnt_q + 2'd1;
        end else if (!last_pix && consume_fire) begin
            full_cnt_d = full_cnt_q - 2'd1;
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= LOAD_LABEL;
            fill_ptr_q    <= 1'b0;
            rd_ptr_q      <= 1'b0;
            full_cnt_q    <= 2'd0;
            loaded_q      <= '0;
            consumed_q    <= '0;
            row_q         <= '0;
            col_q         <= '0;
            image_index_q <= '0;
            label_error_q <= 1'b0;
            all_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fill_ptr_q    <= fill_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            full_cnt_q    <= full_cnt_d;
            loaded_q      <= loaded_d;
            consumed_q    <= consumed_d;
            row_q         <= row_d;
            col_q         <= col_d;
            image_index_q <= image_index_d;
            label_error_q <= label_error_d;
            all_done_q    <= all_done_d;
        end
    end

    // Write the one-hot label and each converted pixel into the fill bank.
    always_ff @(posedge clk) begin
        if (label_fire) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                bank_lbl[fill_ptr_q][c] <= (int'(label_data) == c) ? LABEL_HOT_VALUE : '0;
            end
        end
        if (pix_fire) begin
            bank_pix[fill_ptr_q][row_q][col_q] <= pix_fixed;
        end
    end

    // Present the read bank in parallel to the CNN.
    for (genvar gi = 0; gi < INPUT_DIM_HEIGHT; gi++) begin : g_row
        for (genvar gj = 0; gj < INPUT_DIM_WIDTH; gj++) begin : g_col
            assign output_data[gi][gj] = bank_pix[rd_ptr_q][gi][gj];
        end
    end

    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_lbl
        assign output_labels[gi] = bank_lbl[rd_ptr_q][gi];
    end

    assign frame_valid = (full_cnt_q != 2'd0);
    assign image_index = image_index_q;
    assign label_error = label_error_q;
    assign all_done    = all_done_q;

endmodule

// File: tb/tb_image_stream_loader.sv
// Bench for image_stream_loader: directed frames, a scoreboard of expected
// frames and a monitor that checks each newly presented frame.
module tb_image_stream_loader;

    localparam int H = 28;
    localparam int W = 28;
    localparam int NC = 10;
    localparam int NPIX = H * W;
    localparam int BUDGET = 200;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               label_valid = 1'b0;
    logic [3:0]         label_data = '0;
    logic               label_ready;
    logic               pix_valid = 1'b0;
    logic [7:0]         pix_data = '0;
    logic               pix_ready;
    logic               consume = 1'b0;
    logic signed [31:0] output_data [H][W];
    logic signed [31:0] output_labels [NC];
    logic               frame_valid;
    logic [1:0]         image_index;
    logic               label_error;
    logic               all_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int mul;
        int base;
        int lbl;
        int idx;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    image_stream_loader #(
        .NUM_IMAGES(3)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .label_valid  (label_valid),
        .label_data   (label_data),
        .label_ready  (label_ready),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_ready    (pix_ready),
        .consume      (consume),
        .output_data  (output_data),
        .output_labels(output_labels),
        .frame_valid  (frame_valid),
        .image_index  (image_index),
        .label_error  (label_error),
        .all_done     (all_done)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end else begin
            $display("ok   %s = %0h", name, got);
        end
    endtask

    // Monitor: a frame is newly presented when frame_valid rises or stays
    // high right after an accepted consume.
    bit fv_prev = 1'b0;
    bit cf_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            fv_prev = 1'b0;
            cf_prev = 1'b0;
        end else begin
            if (frame_valid && (!fv_prev || cf_prev)) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame got image_index=%0d required no frame", image_index);
                end else begin
                    exp_t e;
                    int bad_pix;
                    int bad_lbl;
                    logic [31:0] first_got;
                    logic [31:0] first_req;
                    e = sb_q.pop_front();
                    bad_pix = 0;
                    bad_lbl = 0;
                    first_got = '0;
                    first_req = '0;
                    for (int r = 0; r < H; r++) begin
                        for (int c = 0; c < W; c++) begin
                            logic [31:0] req;
                            req = 32'(((r * W + c) * e.mul + e.base) & 255) << 8;
                            if (output_data[r][c] !== req) begin
                                if (bad_pix == 0) begin
                                    first_got = output_data[r][c];
                                    first_req = req;
                                end
                                bad_pix++;
                            end
                        end
                    end
                    checks++;
                    if (bad_pix != 0) begin
                        errors++;
                        $display("FAIL frame%0d_pixels %0d wrong, first got=%0h required=%0h",
                                 e.idx, bad_pix, first_got, first_req);
                    end else begin
                        $display("ok   frame%0d_pixels all %0d match", e.idx, NPIX);
                    end
                    for (int i = 0; i < NC; i++) begin
                        logic [31:0] req;
                        req = (e.lbl == i) ? 32'h0001_0000 : 32'h0;
                        if (output_labels[i] !== req) bad_lbl++;
                    end
                    checks++;
                    if (bad_lbl != 0) begin
                        errors++;
                        $display("FAIL frame%0d_labels %0d elements wrong for label %0d", e.idx, bad_lbl, e.lbl);
                    end else begin
                        $display("ok   frame%0d_labels one-hot for label %0d", e.idx, e.lbl);
                    end
                    checks++;
                    if (int'(image_index) != e.idx) begin
                        errors++;
                        $display("FAIL frame_image_index got=%0d required=%0d", image_index, e.idx);
                    end else begin
                        $display("ok   frame_image_index = %0d", image_index);
                    end
                end
            end
            fv_prev = frame_valid;
            cf_prev = consume && frame_valid;
        end
    end

    // Hold the beat until the DUT accepts it, bounded by BUDGET cycles.
    task automatic wait_xfer(input bit is_pix, input string what);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (is_pix ? pix_ready : label_ready) break;
            n++;
            if (n >= BUDGET) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout got no ready required ready within %0d cycles", what, BUDGET);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_label(input int lbl);
        label_valid = 1'b1;
        label_data  = 4'(lbl);
        wait_xfer(1'b0, "label");
        label_valid = 1'b0;
    endtask

    task automatic send_pixels(input int start, input int count, input int mul, input int base,
                               input bit gaps, input bit cons_last);
        for (int k = start; k < start + count; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    pix_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            pix_valid = 1'b1;
            pix_data  = 8'((k * mul + base) & 255);
            if (cons_last && k == NPIX - 1) consume = 1'b1;
            wait_xfer(1'b1, "pixel");
            pix_valid = 1'b0;
            consume   = 1'b0;
        end
    endtask

    task automatic pulse_consume();
        consume = 1'b1;
        @(posedge clk);
        #1;
        consume = 1'b0;
    endtask

    task automatic do_reset();
        label_valid = 1'b0;
        pix_valid   = 1'b0;
        consume     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_frame_valid", 32'(frame_valid), 32'd0);
        chk("rst_label_ready", 32'(label_ready), 32'd1);
        chk("rst_pix_ready", 32'(pix_ready), 32'd0);
        chk("rst_image_index", 32'(image_index), 32'd0);
        chk("rst_label_error", 32'(label_error), 32'd0);
        chk("rst_all_done", 32'(all_done), 32'd0);
    endtask

    initial begin
        // Group A: latency, back-pressure, stop and all_done.
        do_reset();
        sb_q.push_back('{mul: 0, base: 255, lbl: 3, idx: 0});
        send_label(3);
        send_pixels(0, NPIX - 1, 0, 255, 1'b0, 1'b0);
        chk("a_valid_before_last", 32'(frame_valid), 32'd0);
        send_pixels(NPIX - 1, 1, 0, 255, 1'b0, 1'b0);
        chk("a_valid_after_last", 32'(frame_valid), 32'd1);

        sb_q.push_back('{mul: 1, base: 17, lbl: 0, idx: 1});
        send_label(0);
        send_pixels(0, NPIX, 1, 17, 1'b0, 1'b0);

        label_valid = 1'b1;
        label_data  = 4'd9;
        repeat (3) @(negedge clk);
        chk("a_backpressure_label_ready", 32'(label_ready), 32'd0);
        @(posedge clk);
        #1;
        consume = 1'b1;
        @(negedge clk);
        chk("a_ready_with_consume", 32'(label_ready), 32'd1);
        @(posedge clk);
        #1;
        consume     = 1'b0;
        label_valid = 1'b0;
        chk("a_index_after_consume", 32'(image_index), 32'd1);
        sb_q.push_back('{mul: 3, base: 5, lbl: 9, idx: 2});
        send_pixels(0, NPIX, 3, 5, 1'b0, 1'b0);

        chk("a_stopped_pix_ready", 32'(pix_ready), 32'd0);
        pulse_consume();
        chk("a_stopped_label_ready", 32'(label_ready), 32'd0);
        chk("a_not_done_yet", 32'(all_done), 32'd0);
        pulse_consume();
        chk("a_all_done", 32'(all_done), 32'd1);
        chk("a_final_index", 32'(image_index), 32'd2);
        chk("a_final_valid", 32'(frame_valid), 32'd0);
        pulse_consume();
        chk("a_idle_consume_index", 32'(image_index), 32'd2);
        chk("a_idle_consume_valid", 32'(frame_valid), 32'd0);
        chk("a_idle_consume_done", 32'(all_done), 32'd1);

        // Group B: bad label, then consume coinciding with last pixel.
        do_reset();
        sb_q.push_back('{mul: 0, base: 64, lbl: 12, idx: 0});
        send_label(12);
        chk("b_label_error_set", 32'(label_error), 32'd1);
        send_pixels(0, NPIX, 0, 64, 1'b0, 1'b0);
        sb_q.push_back('{mul: 1, base: 100, lbl: 5, idx: 1});
        send_label(5);
        send_pixels(0, NPIX, 1, 100, 1'b0, 1'b1);
        chk("b_valid_after_overlap", 32'(frame_valid), 32'd1);
        chk("b_index_after_overlap", 32'(image_index), 32'd1);
        chk("b_label_error_sticky", 32'(label_error), 32'd1);
        pulse_consume();
        chk("b_single_frame_left", 32'(frame_valid), 32'd0);

        // Group C: reset mid-frame, then a fresh frame with gaps.
        do_reset();
        send_label(7);
        send_pixels(0, 400, 0, 170, 1'b0, 1'b0);
        do_reset();
        sb_q.push_back('{mul: 1, base: 0, lbl: 1, idx: 0});
        send_label(1);
        send_pixels(0, NPIX, 1, 0, 1'b1, 1'b0);
        chk("c_valid_after_fresh", 32'(frame_valid), 32'd1);
        chk("c_label_error_clear", 32'(label_error), 32'd0);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
